axilite_cmd_sequencer: RTL and testbench

- Upstream command front-end for the AXI-lite master's backend start/done interface.
- Buffers read and write requests from a producer (control/test sequencer) in a DEPTH-entry FIFO.
- Issues exactly one request at a time as a single-cycle bk_wstart/bk_rstart pulse, then waits for bk_wdone/bk_rdone.
- Returns one response per command through a valid/ready response port, with a watchdog timeout so a stalled slave cannot hang the producer.

---
 rtl/axilite_cmd_sequencer_if.sv | 41 ++++
 rtl/axilite_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_axilite_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_cmd_sequencer_if.sv
// Command / response / backend bundle of the AXI-lite command sequencer.
// The master modport is the sequencer's view; the slave modport is the
// producer, response consumer and backend master seen from outside.
interface axilite_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_we;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        bk_wstart;
   logic [31:0] bk_waddr;
   logic [31:0] bk_wdata;
   logic [3:0]  bk_wstrb;
   logic        bk_wdone;
   logic        bk_rstart;
   logic [31:0] bk_raddr;
   logic [31:0] bk_rdata;
   logic        bk_rdone;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
      input  rsp_ready, bk_wdone, bk_rdata, bk_rdone,
      output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
      output bk_wstart, bk_waddr, bk_wdata, bk_wstrb, bk_rstart, bk_raddr
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
      output rsp_ready, bk_wdone, bk_rdata, bk_rdone,
      input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
      input  bk_wstart, bk_waddr, bk_wdata, bk_wstrb, bk_rstart, bk_raddr
   );
endinterface

// File: rtl/axilite_cmd_sequencer.sv
// Command sequencer in front of the AXI-lite master backend: queues
// read/write commands, issues one start pulse at a time, waits for the
// matching done (or a watchdog timeout) and returns one response each.
module axilite_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 256
) (
   input  logic                       axi_aclk,
   input  logic                       axi_aresetn,
   axilite_cmd_sequencer_if.master    bus,
   output logic [$clog2(DEPTH):0]     cmd_count,
   output logic                       busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

   state_t        state;
   state_t        state_next;
   cmd_t          fifo_mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          iss_we;
   logic [31:0]   iss_waddr;
   logic [31:0]   iss_wdata;
   logic [3:0]    iss_wstrb;
   logic [31:0]   iss_raddr;
   logic [TW-1:0] wd_cnt;
   logic          wr_done_hit;
   logic          rd_done_hit;
   logic          timeout_hit;
   logic          rsp_we_q;
   logic [31:0]   rsp_rdata_q;
   logic          rsp_err_q;

   // cmd_ready comes from the registered count only, so a full FIFO refuses
   // a push even in a cycle where the FSM pops.
   assign bus.cmd_ready = (count < CW'(DEPTH));
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign pop           = (state == IDLE) && (count != '0);
   assign head          = fifo_mem[rd_ptr];

   assign wr_done_hit = (state == WAIT) && iss_we && bus.bk_wdone;
   assign rd_done_hit = (state == WAIT) && !iss_we && bus.bk_rdone;
   assign timeout_hit = (state == WAIT) && !wr_done_hit && !rd_done_hit &&
                        (wd_cnt == TW'(TIMEOUT - 1));

   assign bus.bk_wstart = (state == ISSUE) && iss_we;
   assign bus.bk_rstart = (state == ISSUE) && !iss_we;
   assign bus.bk_waddr  = iss_waddr;
   assign bus.bk_wdata  = iss_wdata;
   assign bus.bk_wstrb  = iss_wstrb;
   assign bus.bk_raddr  = iss_raddr;

   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_we    = rsp_we_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign cmd_count = count;
   assign busy      = (state != IDLE) || (count != '0);

   // FIFO storage: payload only, no reset needed.
   always_ff @(posedge axi_aclk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{we: bus.cmd_we, addr: bus.cmd_addr,
                               wdata: bus.cmd_wdata, wstrb: bus.cmd_wstrb};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) state <= IDLE;
      else              state <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pop) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (wr_done_hit || rd_done_hit || timeout_hit) state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Issue registers: only the side matching the popped command is updated,
   // the other side keeps its last value.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         iss_we    <= 1'b0;
         iss_waddr <= '0;
         iss_wdata <= '0;
         iss_wstrb <= '0;
         iss_raddr <= '0;
      end else if (pop) begin
         iss_we <= head.we;
         if (head.we) begin
            iss_waddr <= head.addr;
            iss_wdata <= head.wdata;
            iss_wstrb <= head.wstrb;
         end else begin
            iss_raddr <= head.addr;
         end
      end
   end

   // Watchdog: counts WAIT cycles, restarted by every issue.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)        wd_cnt <= '0;
      else if (state == ISSUE) wd_cnt <= '0;
      else if (state == WAIT)  wd_cnt <= wd_cnt + TW'(1);
   end

   // Response registers, loaded when leaving WAIT and held through RESP.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (wr_done_hit) begin
         rsp_we_q    <= 1'b1;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else if (rd_done_hit) begin
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= bus.bk_rdata;
         rsp_err_q   <= 1'b0;
      end else if (timeout_hit) begin
         rsp_we_q    <= iss_we;
         rsp_rdata_q <= TIMEOUT_RDATA;
         rsp_err_q   <= 1'b1;
      end
   end
endmodule

// File: tb/tb_axilite_cmd_sequencer.sv
// Randomized self-checking bench for axilite_cmd_sequencer with a queue
// based reference model of the command FIFO, backend and responses.
module tb_axilite_cmd_sequencer;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic                   axi_aclk    = 1'b0;
   logic                   axi_aresetn = 1'b0;
   logic [$clog2(DEPTH):0] cmd_count;
   logic                   busy;

   axilite_cmd_sequencer_if bus ();

   axilite_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .axi_aclk    (axi_aclk),
      .axi_aresetn (axi_aresetn),
      .bus         (bus),
      .cmd_count   (cmd_count),
      .busy        (busy)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } cmd_t;

   typedef struct {
      logic        we;
      logic [31:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   cmd_t        cmdq [$];
   rsp_t        expq [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          plan_mode = 0;
   int          fix_d = 1;
   int          rdy_mode = 0;
   logic [31:0] fix_rdata = '0;
   bit          pending = 0;
   bit          blocked_seen = 0;

   initial forever #5 axi_aclk = ~axi_aclk;
   initial forever begin
      @(posedge axi_aclk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Backend responder plus per-cycle occupancy model.
   initial begin
      int          wcnt, plan_d, plan_wrong, late_cnt;
      bit          cur_we, late_we, was_pending;
      logic [31:0] plan_rdata, last_waddr, last_wdata, last_raddr;
      logic [3:0]  last_wstrb;
      cmd_t        c;
      wcnt = 0; plan_d = 0; plan_wrong = 0; late_cnt = 0;
      cur_we = 0; late_we = 0; plan_rdata = '0;
      last_waddr = '0; last_wdata = '0; last_raddr = '0; last_wstrb = '0;
      bus.bk_wdone = 0; bus.bk_rdone = 0; bus.bk_rdata = '0;
      forever begin
         @(negedge axi_aclk);
         bus.bk_wdone = 0;
         bus.bk_rdone = 0;
         bus.bk_rdata = $urandom;
         if (!axi_aresetn) begin
            pending = 0; late_cnt = 0;
            last_waddr = '0; last_wdata = '0; last_raddr = '0; last_wstrb = '0;
            continue;
         end
         was_pending = pending;
         if (late_cnt > 0) begin
            late_cnt--;
            if (late_cnt == 0) begin
               if (late_we) bus.bk_wdone = 1;
               else         bus.bk_rdone = 1;
            end
         end
         if (pending) begin
            wcnt++;
            if (wcnt == 1) chk("start_pulse_len", {bus.bk_wstart, bus.bk_rstart}, 0);
            chk("issue_hold", {bus.bk_waddr, bus.bk_wdata, bus.bk_wstrb, bus.bk_raddr},
                {last_waddr, last_wdata, last_wstrb, last_raddr});
            if (plan_d != 0 && wcnt == plan_d) begin
               if (cur_we) bus.bk_wdone = 1;
               else begin
                  bus.bk_rdone = 1;
                  bus.bk_rdata = plan_rdata;
               end
               expq.push_back('{cur_we, cur_we ? 32'h0 : plan_rdata, 1'b0, cyc + 1});
               pending = 0;
            end else if (plan_d == 0 && wcnt == TIMEOUT) begin
               expq.push_back('{cur_we, 32'hDEAD_BEEF, 1'b1, cyc + 1});
               pending  = 0;
               late_cnt = 2;
               late_we  = cur_we;
            end else if (wcnt == plan_wrong) begin
               if (cur_we) bus.bk_rdone = 1;
               else        bus.bk_wdone = 1;
            end
         end
         if ((bus.bk_wstart || bus.bk_rstart) && !was_pending) begin
            chk("start_excl", bus.bk_wstart && bus.bk_rstart, 0);
            chk("start_legal", 1, (expq.size() == 0) && (cmdq.size() > 0));
            if (cmdq.size() > 0) begin
               c = cmdq.pop_front();
               chk("start_type", bus.bk_wstart, c.we);
               if (c.we) begin
                  last_waddr = c.addr; last_wdata = c.wdata; last_wstrb = c.strb;
               end else begin
                  last_raddr = c.addr;
               end
               chk("issue_fields", {bus.bk_waddr, bus.bk_wdata, bus.bk_wstrb, bus.bk_raddr},
                   {last_waddr, last_wdata, last_wstrb, last_raddr});
               cur_we  = c.we;
               pending = 1;
               wcnt    = 0;
               plan_wrong = 0;
               case (plan_mode)
                  1: begin plan_d = fix_d; plan_rdata = fix_rdata; end
                  2: begin plan_d = 0; plan_rdata = '0; plan_mode = 0; end
                  default: begin
                     plan_d     = $urandom_range(1, 6);
                     plan_rdata = $urandom;
                     if (plan_d > 1 && $urandom_range(0, 1) == 1)
                        plan_wrong = $urandom_range(1, plan_d - 1);
                     if (plan_mode == 3 && $urandom_range(0, 5) == 0) plan_d = 0;
                  end
               endcase
            end
         end
         chk("cmd_count", cmd_count, cmdq.size());
         chk("cmd_ready", bus.cmd_ready, cmdq.size() < DEPTH);
         chk("busy", busy, pending || (cmdq.size() > 0) || (expq.size() > 0));
      end
   end

   // Response consumer and response checker.
   initial begin
      int  held;
      bit  r, exp_v;
      held = 0;
      bus.rsp_ready = 0;
      forever begin
         @(negedge axi_aclk);
         if (!axi_aresetn) begin
            bus.rsp_ready = 0;
            held = 0;
            continue;
         end
         exp_v = (expq.size() > 0) && (cyc >= expq[0].due);
         chk("rsp_valid", bus.rsp_valid, exp_v);
         if (bus.rsp_valid && exp_v) begin
            chk("rsp_we", bus.rsp_we, expq[0].we);
            chk("rsp_rdata", bus.rsp_rdata, expq[0].rdata);
            chk("rsp_err", bus.rsp_err, expq[0].err);
         end
         case (rdy_mode)
            1:       r = 1;
            2:       r = bus.rsp_valid && (held >= 10);
            default: r = ($urandom_range(0, 1) == 1);
         endcase
         if (bus.rsp_valid && !r) held++;
         bus.rsp_ready = r;
         if (bus.rsp_valid && r) begin
            held = 0;
            @(posedge axi_aclk);
            if (exp_v) expq.delete(0);
         end
      end
   end

   task automatic push_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      int   n;
      bit   acc;
      cmd_t c;
      n = 0; acc = 0;
      c.we = we; c.addr = a; c.wdata = d; c.strb = s;
      bus.cmd_valid = 1; bus.cmd_we = we; bus.cmd_addr = a;
      bus.cmd_wdata = d; bus.cmd_wstrb = s;
      while (!acc && n < 200) begin
         acc = bus.cmd_ready;
         if (!acc) blocked_seen = 1;
         @(posedge axi_aclk);
         if (acc) cmdq.push_back(c);
         @(negedge axi_aclk);
         n++;
      end
      bus.cmd_valid = 0;
      chk("push_accept", acc, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((cmdq.size() != 0 || pending || expq.size() != 0) && n < 2000) begin
         @(negedge axi_aclk);
         n++;
      end
      chk(tag, n < 2000, 1);
      repeat (2) @(negedge axi_aclk);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      chk({tag, "_cmd_count"}, cmd_count, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_we, bus.rsp_rdata, bus.rsp_err}, 0);
      chk({tag, "_starts"}, {bus.bk_wstart, bus.bk_rstart}, 0);
      chk({tag, "_bk_fields"}, {bus.bk_waddr, bus.bk_wdata, bus.bk_wstrb, bus.bk_raddr}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int n;
      bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = '0;
      bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
      axi_aresetn = 0;
      repeat (3) @(negedge axi_aclk);
      reset_checks("rst0");
      axi_aresetn = 1;
      @(negedge axi_aclk);

      plan_mode = 1; fix_d = 3; rdy_mode = 1;
      push_cmd(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'hF);
      wait_idle("single_write");

      fix_d = 2; fix_rdata = 32'h1234_5678;
      push_cmd(1'b0, 32'h3000_0020, $urandom, $urandom);
      wait_idle("single_read");

      fix_d = 12; blocked_seen = 0;
      for (int i = 0; i < 6; i++) push_cmd(i[0], $urandom, $urandom, $urandom);
      chk("fill_blocked", blocked_seen, 1);
      wait_idle("fill");

      plan_mode = 1; fix_d = 2; rdy_mode = 2;
      for (int i = 0; i < 3; i++) push_cmd($urandom_range(0, 1), $urandom, $urandom, $urandom);
      wait_idle("rsp_backpressure");

      plan_mode = 2; rdy_mode = 1;
      push_cmd(1'b0, 32'h3000_0040, $urandom, $urandom);
      push_cmd(1'b1, 32'h3000_0044, $urandom, $urandom);
      wait_idle("timeout");

      plan_mode = 3; rdy_mode = 0;
      for (int i = 0; i < 40; i++) begin
         push_cmd($urandom_range(0, 1), $urandom, $urandom, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge axi_aclk);
      end
      wait_idle("random");

      plan_mode = 2; rdy_mode = 1;
      for (int i = 0; i < 3; i++) push_cmd($urandom_range(0, 1), $urandom, $urandom, $urandom);
      n = 0;
      while (!(pending && cmdq.size() == 2) && n < 50) begin
         @(negedge axi_aclk);
         n++;
      end
      chk("reset_setup", n < 50, 1);
      axi_aresetn = 0;
      #1;
      reset_checks("rst_mid");
      cmdq.delete();
      expq.delete();
      repeat (2) @(negedge axi_aclk);
      cmdq.delete();
      expq.delete();
      axi_aresetn = 1;
      repeat (30) @(negedge axi_aclk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
